dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data memory address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter MAX_HOLD, default 16, max consecutive locked grants while the other port waits (range 2..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0/req1  input  1  access request, port 0 = core, port 1 = loader.
REQ-007 lock0/lock1  input  1  requester asks to keep ownership after current access.
REQ-008 we0/we1  input  1  1 = write, 0 = read.
REQ-009 addr0/addr1  input  AW  access address.
REQ-010 wdata0/wdata1  input  DW  write data.
REQ-011 gnt0/gnt1  output  1  access performed this cycle (combinational).
REQ-012 rdata0/rdata1  output  DW  registered read data.
REQ-013 rvalid0/rvalid1  output  1  rdata valid, one cycle after a granted read.
REQ-014 mem_addr  output  AW, mem_read  output 1, mem_write  output 1, mem_wdata  output DW: to data_mem.
REQ-015 mem_rdata  input  DW  data_mem read data, combinational from mem_addr.

Function
REQ-016 States: IDLE (no owner), OWN0, OWN1; one access per cycle, no bubble between accesses.
REQ-017 In OWNx with reqx=1, port x SHALL be granted regardless of the other port, unless a forced release is in effect (REQ-021).
REQ-018 Otherwise (IDLE, or owner not requesting), arbitration among requests: single requester wins; both requesting -> port not served last wins (round-robin pointer `last`).
REQ-019 gntx=1 SHALL drive mem_addr=addrx, mem_wdata=wdatax, mem_write=wex, mem_read=!wex; no grant -> all mem_* outputs 0.
REQ-020 After a granted cycle, next state = OWNx if lockx=1, else IDLE; `last` updates to x on every grant.
REQ-021 Hold counter counts consecutive grants to the same owner; when it reaches MAX_HOLD and the other port is requesting, the next state SHALL be IDLE and the other port SHALL win that arbitration.
REQ-022 Hold counter clears on ownership change or on entering IDLE; saturates at MAX_HOLD.
REQ-023 Granted read: rdatax <= mem_rdata and rvalidx <= 1 at that edge; rvalidx is a single-cycle pulse per read; rdatax holds value until next read on that port.
REQ-024 Owner drops req while other requests in same cycle -> other port granted that cycle (zero-bubble handover).
REQ-025 Address width wrap: arbiter does not modify addresses; addr 8'hFF passes unchanged.
REQ-026 gnt0 and gnt1 SHALL never both be 1.

Reset
REQ-027 While reset=1: state IDLE, `last`=1 (port 0 wins first tie), hold counter 0, gnt*=0, rvalid*=0, rdata*=0, all mem_* outputs 0 (no write leaks to data_mem during reset cycle).
REQ-028 Reset mid-lock SHALL drop ownership; first post-reset cycle arbitrates fresh.

Configuration
REQ-029 Macro DMEM_ARB_PERF_EN defined: add outputs perf_gnt0, perf_gnt1, perf_conflict (16 bits each, saturating at 16'hFFFF, cleared by reset); conflict counts cycles with both req asserted.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package dmem_arb_pkg holds state enum (IDLE, OWN0, OWN1), port index typedef, default AW/DW/MAX_HOLD constants.
REQ-032 One sub-module arb_rr_pick: combinational 2-way round-robin picker (req[1:0], last -> grant index, valid).

Verification
REQ-033 Port 0 read addr 8'h80 with memory[0x80]=8'h5A -> gnt0=1 same cycle, rvalid0=1 and rdata0=8'h5A next cycle.
REQ-034 Both req first cycle after reset -> gnt0; both still requesting, no lock -> gnt1, then gnt0 (alternation).
REQ-035 Port 1 locked writes 0x00..0x13 while port 0 requests continuously, MAX_HOLD=16 -> 16 gnt1 cycles, then gnt0 on cycle 17, memory[0x00..0x0F] written.
REQ-036 Port 0 locked, drops req in same cycle port 1 raises req -> gnt1 that cycle, no idle cycle.
REQ-037 reset asserted during port 1 locked write to 0x10 -> mem_write=0 that cycle, memory[0x10] unchanged, next cycle port 0 wins tie.
REQ-038 With DMEM_ARB_PERF_EN: 10 cycles both requesting -> perf_conflict=10, perf_gnt0=5, perf_gnt1=5.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : ownership state (IDLE, OWN0 = core, OWN1 = loader)
//   port_idx_t  : index of a requester port (0 = core, 1 = loader)
//   DEFAULT_*   : default address width, data width and lock-hold limit
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEFAULT_AW       = 8;
  localparam int DEFAULT_DW       = 8;
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_idx_t;

  // Ownership state that corresponds to a given port.
  function automatic arb_state_t own_state(input port_idx_t p);
    return p ? OWN1 : OWN0;
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
// Combinational two-way round-robin picker.
//   req   : request vector, bit 0 = core, bit 1 = loader
//   last  : port that was served most recently
//   idx   : chosen port (valid only when 'valid' is high)
//   valid : at least one port is requesting
// A lone requester always wins; on a tie the port not served last wins.
// ---------------------------------------------------------------------------
module arb_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output port_idx_t  idx,
  output logic       valid
);

  always_comb begin
    valid = |req;
    idx   = 1'b0;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req[1]) begin
      idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single-ported data memory with a
// combinational read path. One access per cycle, no bubbles.
//   clk, reset            : clock, synchronous active-high reset
//   req/lock/we/addr/wdata: per-port request (0 = core, 1 = loader)
//   gnt0/gnt1             : combinational grant, access happens this cycle
//   rdata/rvalid          : registered read data, rvalid pulses one cycle
//                           after a granted read
//   mem_*                 : data-memory bus, all zero when nothing is granted
// A port that asks for lock keeps ownership after its access; after MAX_HOLD
// consecutive grants to the owner while the other port waits, ownership is
// dropped so the waiting port wins the next arbitration.
// Optional: define DMEM_ARB_PERF_EN to add saturating 16-bit counters
// perf_gnt0, perf_gnt1 and perf_conflict (cycles with both requests high).
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DEFAULT_AW,
  parameter int DW       = DEFAULT_DW,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_gnt0,
  output logic [15:0]   perf_gnt1,
  output logic [15:0]   perf_conflict
`endif
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  arb_state_t state;
  port_idx_t  last;
  logic [7:0] hold_cnt;

  port_idx_t  pick_idx;
  logic       pick_valid;
  port_idx_t  gnt_idx;
  logic       gnt_valid;
  logic       sel_lock;
  logic       sel_we;
  logic       other_req;
  logic [7:0] hold_next;

  arb_rr_pick u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The owner keeps the memory while it requests; otherwise fall back to
  // round-robin. Reset blocks every grant so no write leaks out.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (!reset) begin
      if (state == OWN0 && req0) begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end else if (state == OWN1 && req1) begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end else begin
        gnt_valid = pick_valid;
        gnt_idx   = pick_idx;
      end
    end
  end

  assign gnt0 = gnt_valid && !gnt_idx;
  assign gnt1 = gnt_valid &&  gnt_idx;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    sel_lock  = 1'b0;
    sel_we    = 1'b0;
    other_req = 1'b0;
    if (gnt_valid) begin
      mem_addr  = gnt_idx ? addr1  : addr0;
      mem_wdata = gnt_idx ? wdata1 : wdata0;
      sel_we    = gnt_idx ? we1    : we0;
      sel_lock  = gnt_idx ? lock1  : lock0;
      other_req = gnt_idx ? req0   : req1;
      mem_write = sel_we;
      mem_read  = !sel_we;
    end
  end

  // Consecutive-grant count including the current access: restarts at 1
  // when ownership moves, sticks at the hold limit otherwise.
  always_comb begin
    if (state == own_state(gnt_idx)) begin
      hold_next = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 8'd1;
    end else begin
      hold_next = 8'd1;
    end
  end

  // Ownership FSM plus registered read returns. Reaching the hold limit
  // while the other port waits releases to IDLE; since 'last' then points
  // at the old owner, the waiting port wins the following tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (gnt_valid) begin
        last <= gnt_idx;
        if (sel_lock && !(hold_next >= HOLD_MAX && other_req)) begin
          state    <= own_state(gnt_idx);
          hold_cnt <= hold_next;
        end else begin
          state    <= IDLE;
          hold_cnt <= 8'd0;
        end
        if (!sel_we) begin
          if (gnt_idx) begin
            rdata1  <= mem_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_rdata;
            rvalid0 <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating activity counters for grants and contended cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_gnt0     <= 16'd0;
      perf_gnt1     <= 16'd0;
      perf_conflict <= 16'd0;
    end else begin
      if (gnt0) perf_gnt0 <= sat_inc16(perf_gnt0);
      if (gnt1) perf_gnt1 <= sat_inc16(perf_gnt1);
      if (req0 && req1) perf_conflict <= sat_inc16(perf_conflict);
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   perf_gnt0, perf_gnt1, perf_conflict;
  int            refPerfG0, refPerfG1, refPerfConf;
`endif

  logic [7:0] mem    [256];
  logic [7:0] refMem [256];

  int         refOwner;
  int         refLast;
  int         refHold;
  logic       expRvalid [2];
  logic [7:0] expRdata  [2];
  logic       prevReset;

  logic       obsG0, obsG1;
  int         testsRun    = 0;
  int         testsFailed = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .lock0     (lock0),
    .lock1     (lock1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_gnt0     (perf_gnt0),
    .perf_gnt1     (perf_gnt1),
    .perf_conflict (perf_conflict)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check combinational and registered outputs
  // against the model, then advance the model and the memory across the edge.
  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic l0, input logic w0,
                               input logic [7:0] a0, input logic [7:0] d0,
                               input logic r1, input logic l1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1);
    logic [1:0]  rq;
    int          g;
    logic        gwe, glk;
    logic [7:0]  ga, gd;
    logic [17:0] expBus;
    logic        pendW;
    logic [7:0]  pa, pd;
    reset = rst;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    rq = {r1, r0};
    g  = -1;
    if (!rst) begin
      if (refOwner >= 0 && rq[refOwner]) g = refOwner;
      else if (rq == 2'b11)              g = 1 - refLast;
      else if (r0)                       g = 0;
      else if (r1)                       g = 1;
    end
    gwe = (g == 1) ? w1 : w0;
    glk = (g == 1) ? l1 : l0;
    ga  = (g == 1) ? a1 : a0;
    gd  = (g == 1) ? d1 : d0;
    expBus = (g >= 0) ? {!gwe, gwe, ga, gd} : 18'd0;
    checkOutput("gnt0", 32'(gnt0), 32'(g == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(g == 1));
    checkOutput("mem_bus", 32'({mem_read, mem_write, mem_addr, mem_wdata}), 32'(expBus));
    if (!prevReset) begin
      checkOutput("rvalid0", 32'(rvalid0), 32'(expRvalid[0]));
      checkOutput("rvalid1", 32'(rvalid1), 32'(expRvalid[1]));
      checkOutput("rdata0", 32'(rdata0), 32'(expRdata[0]));
      checkOutput("rdata1", 32'(rdata1), 32'(expRdata[1]));
`ifdef DMEM_ARB_PERF_EN
      checkOutput("perf_gnt0", 32'(perf_gnt0), 32'(refPerfG0));
      checkOutput("perf_gnt1", 32'(perf_gnt1), 32'(refPerfG1));
      checkOutput("perf_conflict", 32'(perf_conflict), 32'(refPerfConf));
`endif
    end
    obsG0 = gnt0;
    obsG1 = gnt1;
    pendW = mem_write;
    pa    = mem_addr;
    pd    = mem_wdata;
    if (rst) begin
      refOwner = -1; refLast = 1; refHold = 0;
      expRvalid[0] = 1'b0; expRvalid[1] = 1'b0;
      expRdata[0]  = 8'h00; expRdata[1]  = 8'h00;
`ifdef DMEM_ARB_PERF_EN
      refPerfG0 = 0; refPerfG1 = 0; refPerfConf = 0;
`endif
    end else begin
`ifdef DMEM_ARB_PERF_EN
      if (g == 0 && refPerfG0 < 65535) refPerfG0++;
      if (g == 1 && refPerfG1 < 65535) refPerfG1++;
      if (rq == 2'b11 && refPerfConf < 65535) refPerfConf++;
`endif
      expRvalid[0] = 1'b0;
      expRvalid[1] = 1'b0;
      if (g >= 0) begin
        if (gwe) refMem[ga] = gd;
        else begin
          expRvalid[g] = 1'b1;
          expRdata[g]  = refMem[ga];
        end
        refHold = (refOwner == g) ? ((refHold + 1 > MAX_HOLD) ? MAX_HOLD : refHold + 1) : 1;
        refLast = g;
        if (glk && !(refHold >= MAX_HOLD && rq[1-g])) refOwner = g;
        else begin
          refOwner = -1;
          refHold  = 0;
        end
      end
    end
    prevReset = rst;
    @(posedge clk);
    #1;
    if (pendW) mem[pa] = pd;
  endtask

  task automatic idleCycle(input logic rst);
    applyStimulus(rst, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] a1Idx;
    logic [7:0] saved;
    logic [7:0] ra0, ra1;
    int         cyc, runG1, errs;
    logic       seq [3];

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h80] = 8'h5A;
    for (int i = 0; i < 256; i++) refMem[i] = mem[i];
    refOwner = -1; refLast = 1; refHold = 0;
    expRvalid[0] = 1'b0; expRvalid[1] = 1'b0;
    expRdata[0] = 8'h00; expRdata[1] = 8'h00;
    prevReset = 1'b1;
`ifdef DMEM_ARB_PERF_EN
    refPerfG0 = 0; refPerfG1 = 0; refPerfConf = 0;
`endif
    #1;

    // Reset with a locked write pending: nothing may reach memory.
    saved = mem[8'h10];
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h11, 1'b1, 1'b1, 1'b1, 8'h10, 8'hEE);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h11, 1'b1, 1'b1, 1'b1, 8'h10, 8'hEE);
    checkOutput("reset_no_write", 32'(mem[8'h10]), 32'(saved));
    checkOutput("reset_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("reset_rdata1", 32'(rdata1), 32'd0);

    // Single read of 0x80 by the core.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("read80_gnt0", 32'(obsG0), 32'd1);
    checkOutput("read80_rvalid0", 32'(rvalid0), 32'd1);
    checkOutput("read80_rdata0", 32'(rdata0), 32'h5A);
    idleCycle(1'b0);
    checkOutput("read80_pulse", 32'(rvalid0), 32'd0);
    checkOutput("read80_hold", 32'(rdata0), 32'h5A);

    // Tie after reset: core first, then alternation.
    idleCycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
      seq[i] = obsG0;
    end
    checkOutput("rr_first_gnt0", 32'(seq[0]), 32'd1);
    checkOutput("rr_second_gnt1", 32'(seq[1]), 32'd0);
    checkOutput("rr_third_gnt0", 32'(seq[2]), 32'd1);

    // Loader locked writes 0x00..0x13 against a continuously requesting core.
    a1Idx = 8'h00; cyc = 0; runG1 = 0;
    while (a1Idx <= 8'h13 && cyc < 60) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, a1Idx, a1Idx ^ 8'hC3);
      if (cyc < 16) runG1 += int'(obsG1);
      if (cyc == 16) checkOutput("hold_release_gnt0", 32'(obsG0), 32'd1);
      if (obsG1) a1Idx++;
      cyc++;
    end
    checkOutput("hold_run_gnt1", 32'(runG1), 32'd16);
    checkOutput("hold_writes_done", 32'(a1Idx), 32'h14);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i] !== (8'(i) ^ 8'hC3)) errs++;
    end
    checkOutput("hold_mem_written", 32'(errs), 32'd0);

    // Locked core drops request while loader raises it: handover same cycle.
    idleCycle(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
    checkOutput("handover_gnt1", 32'(obsG1), 32'd1);

    // Reset during a locked loader write to 0x10.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h30, 8'h44);
    saved = mem[8'h10];
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 8'h99);
    checkOutput("rst_lock_mem10", 32'(mem[8'h10]), 32'(saved));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 8'h99);
    checkOutput("rst_lock_tie_gnt0", 32'(obsG0), 32'd1);

    // Address 0xFF passes through unchanged.
    idleCycle(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    checkOutput("addrFF_rdata1", 32'(rdata1), 32'h3C);

    // Saturated hold: loader owns alone for a long time, then core asks.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'(i), 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 8'h00);
    end

`ifdef DMEM_ARB_PERF_EN
    idleCycle(1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    end
    checkOutput("perf10_conflict", 32'(perf_conflict), 32'd10);
    checkOutput("perf10_gnt0", 32'(perf_gnt0), 32'd5);
    checkOutput("perf10_gnt1", 32'(perf_gnt1), 32'd5);
`endif

    // Random traffic over a small address window plus the top address.
    for (int i = 0; i < 600; i++) begin
      ra0 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ra0, 8'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), 1'($urandom),
                    ra1, 8'($urandom));
    end

    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== refMem[i]) errs++;
    end
    checkOutput("final_memory", 32'(errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
